// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the accumulator calculator.
//   DATA_W  - datapath width (accumulator, operand, result)
//   data_t  - datapath word type
//   op_t    - ALU opcode encoding
//   state_t - command controller FSM state encoding
package alu_pkg;

    localparam int DATA_W = 4;

    typedef logic [DATA_W-1:0] data_t;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_NOT = 3'b101,
        OP_LT  = 3'b110,
        OP_NOP = 3'b111
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu.sv
// alu: purely combinational 4-bit ALU.
//   op - opcode (alu_pkg::op_t)
//   a  - A operand (accumulator)
//   b  - B operand
//   y  - result; ADD/SUB wrap modulo 2^DATA_W, LT yields 1/0 (unsigned)
module alu
    import alu_pkg::*;
(
    input  op_t   op,
    input  data_t a,
    input  data_t b,
    output data_t y
);

    always_comb begin
        y = a;
        case (op)
            OP_ADD:  y = a + b;
            OP_SUB:  y = a - b;
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_NOT:  y = ~a;
            OP_LT:   y = (a < b) ? data_t'(1) : data_t'(0);
            OP_NOP:  y = a;
            default: y = a;
        endcase
    end

endmodule

// File: rtl/alu_calc_ctrl.sv
// alu_calc_ctrl: single-command-at-a-time accumulator calculator.
// A command (opcode + B operand, or a clear) is accepted in IDLE, applied to
// the accumulator in EXEC, and the new accumulator value is offered in RESP.
//
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   cmd_valid/cmd_ready - command handshake
//   cmd_op, cmd_operand - opcode and B operand
//   cmd_clear           - zero the accumulator instead of executing cmd_op
//   res_valid/res_ready - result handshake
//   res_value, res_zero - accumulator value and its zero flag
//   op_count            - completed commands since reset, saturating
//
// Handshake semantics (both channels): a transfer happens on a rising edge
// where valid && ready are both high. The command side is accepted only in
// IDLE; cmd_valid at any other time is ignored. The result side holds
// res_valid and the result data stable until the consumer takes it.
module alu_calc_ctrl
    import alu_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [3:0]       cmd_operand,
    input  logic             cmd_clear,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [3:0]       res_value,
    output logic             res_zero,
    output logic [CNT_W-1:0] op_count
);

    state_t           state;
    state_t           state_nxt;
    logic             run_en;      // low until the first edge after reset release
    op_t              op_q;
    data_t            operand_q;
    logic             clear_q;
    data_t            acc;
    data_t            alu_y;
    logic             cmd_fire;
    logic             res_fire;

    alu u_alu (
        .op (op_q),
        .a  (acc),
        .b  (operand_q),
        .y  (alu_y)
    );

    // FSM next state and handshake outputs.
    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        res_valid = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = run_en;
                if (cmd_valid && run_en) begin
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                state_nxt = RESP;
            end
            RESP: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign cmd_fire = cmd_valid && cmd_ready;
    assign res_fire = res_valid && res_ready;

    // The accumulator only changes in EXEC, so driving the result straight
    // from it keeps res_value/res_zero stable for the whole RESP phase.
    assign res_value = acc;
    assign res_zero  = (acc == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            run_en    <= 1'b0;
            op_q      <= OP_ADD;
            operand_q <= '0;
            clear_q   <= 1'b0;
            acc       <= '0;
            op_count  <= '0;
        end else begin
            state  <= state_nxt;
            run_en <= 1'b1;
            if (cmd_fire) begin
                op_q      <= op_t'(cmd_op);
                operand_q <= cmd_operand;
                clear_q   <= cmd_clear;
            end
            if (state == EXEC) begin
                acc <= clear_q ? data_t'(0) : alu_y;
            end
            if (res_fire && (op_count != '1)) begin
                op_count <= op_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_alu_calc_ctrl.sv
// tb_alu_calc_ctrl: randomized self-checking bench for alu_calc_ctrl.
// A transaction-level model predicts each accumulator result; a negedge
// compare process checks outputs every cycle against an expected queue.
module tb_alu_calc_ctrl;

    localparam int CLK_HALF = 5;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #CLK_HALF clk = ~clk;

    // ---------------- main DUT (CNT_W = 8) ----------------
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [2:0] cmd_op = 3'd0;
    logic [3:0] cmd_operand = 4'd0;
    logic       cmd_clear = 1'b0;
    logic       res_valid;
    logic       res_ready = 1'b0;
    logic [3:0] res_value;
    logic       res_zero;
    logic [7:0] op_count;

    alu_calc_ctrl #(.CNT_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_operand (cmd_operand),
        .cmd_clear   (cmd_clear),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_value   (res_value),
        .res_zero    (res_zero),
        .op_count    (op_count)
    );

    // ---------------- second DUT (CNT_W = 2) ----------------
    logic       cmd_valid2 = 1'b0;
    logic       cmd_ready2;
    logic       res_valid2;
    logic [3:0] res_value2;
    logic       res_zero2;
    logic [1:0] op_count2;

    alu_calc_ctrl #(.CNT_W(2)) dut2 (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid2),
        .cmd_ready   (cmd_ready2),
        .cmd_op      (3'd0),
        .cmd_operand (4'd1),
        .cmd_clear   (1'b0),
        .res_valid   (res_valid2),
        .res_ready   (1'b1),
        .res_value   (res_value2),
        .res_zero    (res_zero2),
        .op_count    (op_count2)
    );

    // ---------------- scoreboard state ----------------
    int         checks = 0;
    int         errors = 0;
    logic [3:0] exp_q[$];
    int         acc_m = 0;
    int         count_m = 0;
    logic [3:0] got;

    task automatic chk(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference ALU written from the opcode table with plain integer math.
    function automatic logic [3:0] model(input logic [2:0] op, input int a, input int b);
        int r;
        case (op)
            3'd0:    r = (a + b) % 16;
            3'd1:    r = (a - b + 16) % 16;
            3'd2:    r = a & b;
            3'd3:    r = a | b;
            3'd4:    r = a ^ b;
            3'd5:    r = 15 - a;
            3'd6:    r = (a < b) ? 1 : 0;
            default: r = a;
        endcase
        return 4'(r);
    endfunction

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            chk("valid_ready_excl", 32'(res_valid && cmd_ready), 32'd0);
            chk("op_count", 32'(op_count), 32'(count_m));
            if (res_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_resp", 32'd1, 32'd0);
                end else begin
                    chk("res_value", 32'(res_value), 32'(exp_q[0]));
                    chk("res_zero", 32'(res_zero), 32'(exp_q[0] == 4'd0));
                    if (res_ready) begin
                        void'(exp_q.pop_front());
                        if (count_m < 255) count_m++;
                    end
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic wait_ready();
        int n = 0;
        while (!cmd_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!cmd_ready) chk("cmd_ready_timeout", 32'd0, 32'd1);
    endtask

    // Issue one command; hold = cycles of res_ready low once RESP is reached.
    task automatic send(input logic [2:0] op, input logic [3:0] b, input logic clr, input int hold);
        wait_ready();
        cmd_valid   = 1'b1;
        cmd_op      = op;
        cmd_operand = b;
        cmd_clear   = clr;
        res_ready   = (hold == 0);
        @(posedge clk);
        acc_m = clr ? 0 : int'(model(op, acc_m, int'(b)));
        exp_q.push_back(4'(acc_m));
        #1;
        cmd_valid   = 1'($urandom_range(0, 1));
        cmd_op      = 3'($urandom_range(0, 7));
        cmd_operand = 4'($urandom_range(0, 15));
        chk("lat_exec_no_valid", 32'(res_valid), 32'd0);
        @(posedge clk); #1;
        chk("lat_resp_valid", 32'(res_valid), 32'd1);
        got = res_value;
        for (int i = 0; i < hold; i++) begin
            cmd_valid   = 1'($urandom_range(0, 1));
            cmd_op      = 3'($urandom_range(0, 7));
            cmd_operand = 4'($urandom_range(0, 15));
            @(posedge clk); #1;
            chk("held_valid", 32'(res_valid), 32'd1);
        end
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        @(posedge clk); #1;
        chk("resp_one_cycle", 32'(res_valid), 32'd0);
        res_ready = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int exp2[5] = '{1, 2, 3, 3, 3};
        int n;

        // reset state while rst_n is low
        #2;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_value", 32'(res_value), 32'd0);
        chk("rst_res_zero", 32'(res_zero), 32'd1);
        chk("rst_op_count", 32'(op_count), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1 chk("rel_cmd_ready_low", 32'(cmd_ready), 32'd0);
        @(posedge clk); #1;
        chk("rel_cmd_ready_high", 32'(cmd_ready), 32'd1);

        // directed: clear, ADD 3, ADD 5, SUB 5
        send(3'd0, 4'd9, 1'b1, 0); chk("seq_clear", 32'(got), 32'd0);
        send(3'd0, 4'd3, 1'b0, 0); chk("seq_add3", 32'(got), 32'd3);
        send(3'd0, 4'd5, 1'b0, 0); chk("seq_add5", 32'(got), 32'd8);
        send(3'd1, 4'd5, 1'b0, 0); chk("seq_sub5", 32'(got), 32'd3);
        chk("seq_count4", 32'(op_count), 32'd4);

        // wrap and zero flag
        send(3'd0, 4'd15, 1'b0, 0); chk("wrap_add15", 32'(got), 32'd2);
        send(3'd1, 4'd2, 1'b0, 0);  chk("sub_to_zero", 32'(got), 32'd0);

        // LT, NOT, NOP
        send(3'd0, 4'd2, 1'b0, 0); chk("set_acc2", 32'(got), 32'd2);
        send(3'd6, 4'd5, 1'b0, 0); chk("lt_true", 32'(got), 32'd1);
        send(3'd6, 4'd0, 1'b0, 0); chk("lt_false", 32'(got), 32'd0);
        send(3'd5, 4'd7, 1'b0, 0); chk("not_zero", 32'(got), 32'd15);
        send(3'd7, 4'd3, 1'b0, 0); chk("nop", 32'(got), 32'd15);

        // backpressure with ignored cmd_valid pulses
        send(3'd4, 4'd5, 1'b0, 4); chk("bp_xor", 32'(got), 32'd10);
        chk("bp_count", 32'(op_count), 32'd12);

        // randomized commands and backpressure
        for (int i = 0; i < 40; i++) begin
            send(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 7) == 0), int'($urandom_range(0, 3)));
        end
        chk("rand_drained", 32'(exp_q.size()), 32'd0);

        // reset while the command is in EXEC
        wait_ready();
        cmd_valid = 1'b1; cmd_op = 3'd0; cmd_operand = 4'd7; cmd_clear = 1'b0;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        rst_n = 1'b0;
        exp_q.delete();
        acc_m = 0;
        count_m = 0;
        #1;
        chk("mid_rst_res_valid", 32'(res_valid), 32'd0);
        chk("mid_rst_acc", 32'(res_value), 32'd0);
        chk("mid_rst_count", 32'(op_count), 32'd0);
        chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("post_rst_no_resp", 32'(res_valid), 32'd0);
            chk("post_rst_idle", 32'(cmd_ready), 32'd1);
        end

        // CNT_W = 2 saturation on the second instance
        for (int i = 0; i < 5; i++) begin
            n = 0;
            while (!cmd_ready2 && n < 50) begin @(posedge clk); #1; n++; end
            cmd_valid2 = 1'b1;
            @(posedge clk); #1;
            cmd_valid2 = 1'b0;
            n = 0;
            while (!res_valid2 && n < 20) begin @(posedge clk); #1; n++; end
            if (!res_valid2) chk("sat_resp_timeout", 32'd0, 32'd1);
            @(posedge clk); #1;
            chk("sat_op_count", 32'(op_count2), 32'(exp2[i]));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // global time limit
    initial begin
        #200000;
        errors++;
        $display("FAIL global_timeout: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
